// File: rtl/input_ctrl_pkg.sv
// input_ctrl_pkg: shared widths and ev_data field layout for input_event_ctrl
package input_ctrl_pkg;
   localparam int BTN_N       = 4;
   localparam int SW_N        = 8;
   localparam int EV_EDGE_BIT = 10;
   localparam int EV_ID_LSB   = 8;
   localparam int EV_SW_LSB   = 0;
   localparam int EV_W        = 11;

   function automatic logic [EV_W-1:0] pack_ev(input logic lvl, input logic [1:0] id, input logic [SW_N-1:0] sw);
      logic [EV_W-1:0] ev;
      ev = '0;
      ev[EV_EDGE_BIT] = lvl;
      ev[EV_ID_LSB +: 2] = id;
      ev[EV_SW_LSB +: SW_N] = sw;
      return ev;
   endfunction
endpackage

// File: rtl/debounce_cell.sv
// debounce_cell: synchronizes one raw button, debounces it and pulses on each accepted level change
module debounce_cell
   import input_ctrl_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 50000
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic state,
   output logic pulse
);
   logic [1:0]  sync;
   logic [15:0] cnt;
   logic        mismatch;

   assign mismatch = sync[1] != state;
   assign pulse    = mismatch && cnt == 16'(DEBOUNCE_CYCLES - 1);

   // two-flop synchronizer for the asynchronous button
   always_ff @(posedge clk or posedge rst)
      if (rst) sync <= '0;
      else sync <= {sync[0], raw};

   // count consecutive mismatch cycles; flip the level once the input has been stable long enough
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         cnt   <= '0;
         state <= 1'b0;
      end else if (pulse) begin
         cnt   <= '0;
         state <= ~state;
      end else cnt <= mismatch ? cnt + 16'd1 : '0;
endmodule

// File: rtl/input_event_ctrl.sv
// input_event_ctrl: debounced buttons -> prioritized event FIFO with switch snapshot; INPUT_IRQ_EN adds irq output
module input_event_ctrl
   import input_ctrl_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int FIFO_DEPTH      = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [BTN_N-1:0] btn_in,
   input  logic [SW_N-1:0]  sw_in,
   output logic [BTN_N-1:0] btn_state,
   output logic             ev_valid,
   input  logic             ev_ready,
   output logic [EV_W-1:0]  ev_data,
   output logic             ev_overflow,
   input  logic             ovf_clr
`ifdef INPUT_IRQ_EN
   ,
   output logic             irq
`endif
);
   localparam int AW = $clog2(FIFO_DEPTH);

   logic [BTN_N-1:0] pulse, pend, pend_edge, grant, taken;
   logic [SW_N-1:0]  sw_s1, sw_s2;
   logic [EV_W-1:0]  mem [FIFO_DEPTH];
   logic [AW:0]      wptr, rptr;
   logic [1:0]       sel;
   logic             full, pop, push, ovf_set;

   genvar i;
   for (i = 0; i < BTN_N; i++) begin : g_cell
      debounce_cell #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cell (
         .clk  (clk),
         .rst  (rst),
         .raw  (btn_in[i]),
         .state(btn_state[i]),
         .pulse(pulse[i])
      );
   end

   // lowest pending button wins; a pushed button's pend bit is released this cycle
   always_comb begin
      grant   = pend & (~pend + BTN_N'(1));
      sel     = grant[1] ? 2'd1 : grant[2] ? 2'd2 : grant[3] ? 2'd3 : 2'd0;
      full    = wptr[AW] != rptr[AW] && wptr[AW-1:0] == rptr[AW-1:0];
      ev_valid = wptr != rptr;
      pop     = ev_valid & ev_ready;
      push    = |pend && (!full || pop);
      taken   = push ? grant : '0;
      ovf_set = |(pulse & pend & ~taken);
      ev_data = mem[rptr[AW-1:0]];
   end

   // two-flop synchronizer for the switches, sampled into each pushed event
   always_ff @(posedge clk or posedge rst)
      if (rst) {sw_s2, sw_s1} <= '0;
      else {sw_s2, sw_s1} <= {sw_s1, sw_in};

   // event FIFO storage and wrap-bit pointers
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         wptr <= '0;
         rptr <= '0;
         for (int k = 0; k < FIFO_DEPTH; k++) mem[k] <= '0;
      end else begin
         if (push) begin
            mem[wptr[AW-1:0]] <= pack_ev(pend_edge[sel], sel, sw_s2);
            wptr <= wptr + (AW+1)'(1);
         end
         rptr <= rptr + {{AW{1'b0}}, pop};
      end

   // pending edges; a new edge overwrites the recorded level of a still-pending button
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         pend      <= '0;
         pend_edge <= '0;
      end else begin
         pend      <= (pend & ~taken) | pulse;
         pend_edge <= (pend_edge & ~pulse) | (pulse & ~btn_state);
      end

   // sticky loss flag; a new loss wins over a simultaneous clear
   always_ff @(posedge clk or posedge rst)
      if (rst) ev_overflow <= 1'b0;
      else ev_overflow <= ovf_set | (ev_overflow & ~ovf_clr);

`ifdef INPUT_IRQ_EN
   // registered interrupt request, one cycle behind its sources
   always_ff @(posedge clk or posedge rst)
      if (rst) irq <= 1'b0;
      else irq <= ev_valid | ev_overflow;
`endif
endmodule
